// File: rtl/fma_read_buffer_if.sv
// Memory-to-FMA line buffer bundle: line capture side, operand side, status.
// Parameter set mirrors fma_read_buffer; line width is derived, not free.
interface fma_read_buffer_if #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4
);
    localparam int LW = FMA_COUNT * 3 * WORD_WIDTH;
    localparam int OW = FMA_COUNT * WORD_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LW-1:0] line_in;
    logic          line_valid_in;
    logic          flush_in;
    logic          fma_ready_in;
    logic [OW-1:0] a_out;
    logic [OW-1:0] b_out;
    logic [OW-1:0] c_out;
    logic          valid_out;
    logic          full_out;
    logic          empty_out;
    logic [CW-1:0] count_out;
    logic          overflow_out;

    modport master (
        output line_in, line_valid_in, flush_in, fma_ready_in,
        input  a_out, b_out, c_out, valid_out,
        input  full_out, empty_out, count_out, overflow_out
    );

    modport slave (
        input  line_in, line_valid_in, flush_in, fma_ready_in,
        output a_out, b_out, c_out, valid_out,
        output full_out, empty_out, count_out, overflow_out
    );
endinterface

// File: rtl/fma_read_buffer.sv
// Line FIFO between the cache abc output and the FMA array, unpacked per lane.
// Define FMA_READ_BUFFER_BYPASS_EN for a zero-latency path when empty.
module fma_read_buffer #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 96,
    parameter int DEPTH      = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    fma_read_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = FMA_COUNT * WORD_WIDTH;

    logic [LINE_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_valid;
    logic [LINE_WIDTH-1:0] w_line;
    logic [OW-1:0]         w_a;
    logic [OW-1:0]         w_b;
    logic [OW-1:0]         w_c;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef FMA_READ_BUFFER_BYPASS_EN
    assign w_bypass = w_empty & bus.line_valid_in
                    & bus.fma_ready_in & ~bus.flush_in;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop  = ~w_empty & bus.fma_ready_in & ~bus.flush_in;
    assign w_push = bus.line_valid_in & ~bus.flush_in & ~w_bypass
                  & (~w_full | w_pop);
    assign w_drop = bus.line_valid_in & ~bus.flush_in & w_full & ~w_pop;
    assign w_valid = ~w_empty | w_bypass;

    // Word 0 sits at the MSBs; lane i takes words 3i, 3i+1, 3i+2.
    always_comb begin
        w_line = '0;
        w_a    = '0;
        w_b    = '0;
        w_c    = '0;
        if (w_bypass) begin
            w_line = bus.line_in;
        end else if (!w_empty) begin
            w_line = r_mem[r_rd_ptr];
        end
        for (int i = 0; i < FMA_COUNT; i++) begin
            w_a[i*WORD_WIDTH +: WORD_WIDTH] =
                w_line[LINE_WIDTH-(3*i+1)*WORD_WIDTH +: WORD_WIDTH];
            w_b[i*WORD_WIDTH +: WORD_WIDTH] =
                w_line[LINE_WIDTH-(3*i+2)*WORD_WIDTH +: WORD_WIDTH];
            w_c[i*WORD_WIDTH +: WORD_WIDTH] =
                w_line[LINE_WIDTH-(3*i+3)*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: nothing is read while the count is zero.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.line_in;
    end

    assign bus.a_out        = w_a;
    assign bus.b_out        = w_b;
    assign bus.c_out        = w_c;
    assign bus.valid_out    = w_valid;
    assign bus.full_out     = w_full;
    assign bus.empty_out    = w_empty;
    assign bus.count_out    = r_count;
    assign bus.overflow_out = r_ovf;
endmodule

// File: tb/tb_fma_read_buffer.sv
// Directed bench for fma_read_buffer: ordering, overflow, flush, async reset,
// and the same-cycle path when FMA_READ_BUFFER_BYPASS_EN is defined.
module tb_fma_read_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fma_read_buffer_if #(.FMA_COUNT(2), .WORD_WIDTH(16), .DEPTH(4)) bus ();

    fma_read_buffer #(
        .FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96), .DEPTH(4)
    ) u_dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Line with words base..base+5, word 0 at the MSBs.
    function automatic logic [95:0] mk(input logic [15:0] b);
        return {b, b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4, b + 16'd5};
    endfunction
    function automatic logic [31:0] ea(input logic [15:0] b);
        return {b + 16'd3, b};
    endfunction
    function automatic logic [31:0] eb(input logic [15:0] b);
        return {b + 16'd4, b + 16'd1};
    endfunction
    function automatic logic [31:0] ec(input logic [15:0] b);
        return {b + 16'd5, b + 16'd2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int first);
        bus.fma_ready_in  = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.line_in       = mk(16'(4096 * (first + k)));
            bus.line_valid_in = 1'b1;
            tick();
        end
        bus.line_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1 ||
            bus.full_out !== 1'b0 || bus.valid_out !== 1'b0 ||
            bus.overflow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags cnt=%0d e=%b f=%b v=%b o=%b req 0 1 0 0 0",
                     bus.count_out, bus.empty_out, bus.full_out,
                     bus.valid_out, bus.overflow_out);
        end
        n_tests++;
        if (bus.a_out !== 32'h0 || bus.b_out !== 32'h0 || bus.c_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ops a=%h b=%h c=%h req 0", bus.a_out,
                     bus.b_out, bus.c_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.line_in       = 96'h0001_0002_0003_0004_0005_0006;
        bus.line_valid_in = 1'b1;
        bus.fma_ready_in  = 1'b1;
`ifdef FMA_READ_BUFFER_BYPASS_EN
        #1;
        n_tests++;
        if (bus.valid_out !== 1'b1 || bus.a_out !== 32'h0004_0001 ||
            bus.b_out !== 32'h0005_0002 || bus.c_out !== 32'h0006_0003) begin
            n_fail++;
            $display("FAIL single_byp v=%b a=%h b=%h c=%h", bus.valid_out,
                     bus.a_out, bus.b_out, bus.c_out);
        end
        tick();
        bus.line_valid_in = 1'b0;
`else
        tick();
        bus.line_valid_in = 1'b0;
        n_tests++;
        if (bus.valid_out !== 1'b1 || bus.a_out !== 32'h0004_0001 ||
            bus.b_out !== 32'h0005_0002 || bus.c_out !== 32'h0006_0003) begin
            n_fail++;
            $display("FAIL single_ops v=%b a=%h b=%h c=%h req 1 00040001 00050002 00060003",
                     bus.valid_out, bus.a_out, bus.b_out, bus.c_out);
        end
        tick();
`endif
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain cnt=%0d v=%b req 0 0", bus.count_out,
                     bus.valid_out);
        end
    endtask

    task automatic test_empty_pop();
        bus.fma_ready_in = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1 ||
            bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pop cnt=%0d e=%b v=%b req 0 1 0",
                     bus.count_out, bus.empty_out, bus.valid_out);
        end
    endtask

    task automatic drain_check(input string name, input int first);
        bus.line_valid_in = 1'b0;
        bus.fma_ready_in  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] bs;
            bs = 16'(4096 * (first + k));
            n_tests++;
            if (bus.valid_out !== 1'b1 || bus.a_out !== ea(bs) ||
                bus.b_out !== eb(bs) || bus.c_out !== ec(bs)) begin
                n_fail++;
                $display("FAIL %s_order%0d v=%b a=%h req a=%h", name, k,
                         bus.valid_out, bus.a_out, ea(bs));
            end
            tick();
        end
        n_tests++;
        if (bus.valid_out !== 1'b0 || bus.count_out !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_empty v=%b cnt=%0d req 0 0", name,
                     bus.valid_out, bus.count_out);
        end
    endtask

    task automatic test_overflow();
        push_n(4, 1);
        n_tests++;
        if (bus.count_out !== 3'd4 || bus.full_out !== 1'b1 ||
            bus.overflow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL fill cnt=%0d f=%b o=%b req 4 1 0", bus.count_out,
                     bus.full_out, bus.overflow_out);
        end
        push_n(1, 5);
        n_tests++;
        if (bus.count_out !== 3'd4 || bus.overflow_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf cnt=%0d o=%b req 4 1", bus.count_out,
                     bus.overflow_out);
        end
        drain_check("ovf", 1);
        n_tests++;
        if (bus.overflow_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky o=%b req 1", bus.overflow_out);
        end
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
    endtask

    task automatic test_full_push_pop();
        push_n(4, 1);
        bus.line_in       = mk(16'h5000);
        bus.line_valid_in = 1'b1;
        bus.fma_ready_in  = 1'b1;
        tick();
        bus.line_valid_in = 1'b0;
        n_tests++;
        if (bus.count_out !== 3'd4 || bus.overflow_out !== 1'b0 ||
            bus.full_out !== 1'b1) begin
            n_fail++;
            $display("FAIL fpp cnt=%0d o=%b f=%b req 4 0 1", bus.count_out,
                     bus.overflow_out, bus.full_out);
        end
        drain_check("fpp", 2);
    endtask

    task automatic test_flush();
        push_n(4, 1);
        push_n(1, 5);
        bus.fma_ready_in = 1'b1;
        tick();
        bus.fma_ready_in = 1'b0;
        n_tests++;
        if (bus.count_out !== 3'd3 || bus.overflow_out !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_flush cnt=%0d o=%b req 3 1", bus.count_out,
                     bus.overflow_out);
        end
        bus.flush_in      = 1'b1;
        bus.line_in       = mk(16'h9000);
        bus.line_valid_in = 1'b1;
        tick();
        bus.flush_in      = 1'b0;
        bus.line_valid_in = 1'b0;
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1 ||
            bus.valid_out !== 1'b0 || bus.overflow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush cnt=%0d e=%b v=%b o=%b req 0 1 0 0",
                     bus.count_out, bus.empty_out, bus.valid_out,
                     bus.overflow_out);
        end
        tick();
        push_n(1, 10);
        n_tests++;
        if (bus.count_out !== 3'd1 || bus.a_out !== ea(16'hA000)) begin
            n_fail++;
            $display("FAIL post_flush cnt=%0d a=%h req 1 %h", bus.count_out,
                     bus.a_out, ea(16'hA000));
        end
        bus.fma_ready_in = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        push_n(2, 1);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.valid_out !== 1'b0 ||
            bus.empty_out !== 1'b1 || bus.a_out !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst cnt=%0d v=%b e=%b a=%h req 0 0 1 0",
                     bus.count_out, bus.valid_out, bus.empty_out, bus.a_out);
        end
        #1;
        rst = 1'b0;
        push_n(1, 11);
        n_tests++;
        if (bus.count_out !== 3'd1 || bus.a_out !== ea(16'hB000) ||
            bus.c_out !== ec(16'hB000)) begin
            n_fail++;
            $display("FAIL post_rst cnt=%0d a=%h req 1 %h", bus.count_out,
                     bus.a_out, ea(16'hB000));
        end
        bus.fma_ready_in = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        bus.line_in       = mk(16'hC000);
        bus.line_valid_in = 1'b1;
        bus.fma_ready_in  = 1'b1;
        #1;
`ifdef FMA_READ_BUFFER_BYPASS_EN
        n_tests++;
        if (bus.valid_out !== 1'b1 || bus.a_out !== ea(16'hC000) ||
            bus.b_out !== eb(16'hC000)) begin
            n_fail++;
            $display("FAIL byp_same v=%b a=%h req 1 %h", bus.valid_out,
                     bus.a_out, ea(16'hC000));
        end
        tick();
        bus.line_valid_in = 1'b0;
        n_tests++;
        if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1) begin
            n_fail++;
            $display("FAIL byp_cnt cnt=%0d e=%b req 0 1", bus.count_out,
                     bus.empty_out);
        end
`else
        n_tests++;
        if (bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL nobyp_same v=%b req 0", bus.valid_out);
        end
        tick();
        bus.line_valid_in = 1'b0;
        n_tests++;
        if (bus.valid_out !== 1'b1 || bus.a_out !== ea(16'hC000) ||
            bus.count_out !== 3'd1) begin
            n_fail++;
            $display("FAIL nobyp_next v=%b a=%h cnt=%0d req 1 %h 1",
                     bus.valid_out, bus.a_out, bus.count_out, ea(16'hC000));
        end
        tick();
`endif
    endtask

    initial begin
        bus.line_in       = '0;
        bus.line_valid_in = 1'b0;
        bus.flush_in      = 1'b0;
        bus.fma_ready_in  = 1'b0;
        test_reset();
        test_single();
        test_empty_pop();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
